// File: rtl/pixel_column_reader_pkg.sv
// Shared pixel types for the column reader: Pixel, PixelArray, PipelineHeight.
// Also holds the reader FSM state encoding.
package pixel_column_reader_pkg;

   localparam int PipelineHeight = 5;

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } Pixel;

   typedef Pixel [0:PipelineHeight-1] PixelArray;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      ASSEMBLE = 1'b1
   } reader_state_t;

endpackage

// File: rtl/pixel_column_reader_rgb_byte_packer.sv
// rgb_byte_packer: packs R,G,B bytes into a Pixel; pixel_valid on the blue byte.
// Ports: clock, reset_n, data, load (next byte), restart (byte is a new red), phase, pixel, pixel_valid.
module rgb_byte_packer
   import pixel_column_reader_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] data,
   input  logic       load,
   input  logic       restart,
   output logic [1:0] phase,
   output Pixel       pixel,
   output logic       pixel_valid
);

   logic [7:0] red_q;
   logic [7:0] green_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase   <= 2'd0;
         red_q   <= '0;
         green_q <= '0;
      end else if (restart) begin
         red_q <= data;
         phase <= 2'd1;
      end else if (load) begin
         unique case (phase)
            2'd0: begin
               red_q <= data;
               phase <= 2'd1;
            end
            2'd1: begin
               green_q <= data;
               phase   <= 2'd2;
            end
            default: phase <= 2'd0;
         endcase
      end
   end

   // Blue is taken straight from the bus so the pixel lands the same cycle.
   assign pixel = '{red: red_q, green: green_q, blue: data};
   assign pixel_valid = load && !restart && (phase == 2'd2);

endmodule

// File: rtl/pixel_column_reader.sv
// Byte-stream (R,G,B + sof) to PixelArray column deserializer with valid/ready output.
// Ports: clock, reset_n, in_* byte stream, out_* column, sync_error, error_count (PIXEL_READER_ERRCNT_EN).
module pixel_column_reader #(
   parameter int PipelineHeight = pixel_column_reader_pkg::PipelineHeight,
   parameter int ImageWidth     = 640
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic [7:0]                          in_data,
   input  logic                                in_valid,
   input  logic                                in_sof,
   output logic                                in_ready,
   output pixel_column_reader_pkg::PixelArray  out_pixels,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                out_first_column,
   output logic                                out_last_column,
   output logic                                sync_error,
   output logic [15:0]                         error_count
);

   import pixel_column_reader_pkg::*;

   localparam int RowW = (PipelineHeight > 1) ? $clog2(PipelineHeight) : 1;
   localparam int ColW = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
   localparam logic [RowW-1:0] LastRow = RowW'(PipelineHeight - 1);
   localparam logic [ColW-1:0] LastCol = ColW'(ImageWidth - 1);

   reader_state_t   state_q;
   logic [RowW-1:0] row_q;
   logic [ColW-1:0] col_q;
   PixelArray       asm_q;
   PixelArray       col_next;

   logic [1:0] phase;
   Pixel       pixel;
   logic       pixel_valid;

   logic accept;
   logic sof_hit;
   logic at_origin;
   logic sof_error;
   logic pk_load;
   logic last_slot;
   logic col_done;

   // Only the byte that would complete a column waits on a full output.
   assign last_slot = (state_q == ASSEMBLE) && (phase == 2'd2)
                   && (row_q == LastRow);
   assign in_ready  = !(out_valid && !out_ready) || !last_slot;
   assign accept    = in_valid && in_ready;
   assign sof_hit   = accept && in_sof;
   assign at_origin = (phase == 2'd0) && (row_q == '0) && (col_q == '0);
   assign sof_error = sof_hit && (state_q == ASSEMBLE) && !at_origin;
   assign pk_load   = accept && !in_sof && (state_q == ASSEMBLE);
   assign col_done  = pixel_valid && (row_q == LastRow);

   rgb_byte_packer u_packer (
      .clock       (clock),
      .reset_n     (reset_n),
      .data        (in_data),
      .load        (pk_load),
      .restart     (sof_hit),
      .phase       (phase),
      .pixel       (pixel),
      .pixel_valid (pixel_valid)
   );

   always_comb begin
      col_next = asm_q;
      col_next[PipelineHeight-1] = pixel;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= WAIT_SOF;
         row_q            <= '0;
         col_q            <= '0;
         asm_q            <= '0;
         out_pixels       <= '0;
         out_valid        <= 1'b0;
         out_first_column <= 1'b0;
         out_last_column  <= 1'b0;
         sync_error       <= 1'b0;
      end else begin
         sync_error <= sof_error;

         // A stray sof drops the partial column; stale rows get overwritten.
         if (sof_hit) begin
            state_q <= ASSEMBLE;
            row_q   <= '0;
            col_q   <= '0;
         end else if (pixel_valid) begin
            asm_q[row_q] <= pixel;
            if (row_q == LastRow) begin
               row_q <= '0;
               if (col_q == LastCol) begin
                  col_q   <= '0;
                  state_q <= WAIT_SOF;
               end else begin
                  col_q <= col_q + ColW'(1);
               end
            end else begin
               row_q <= row_q + RowW'(1);
            end
         end

         if (col_done) begin
            out_pixels       <= col_next;
            out_first_column <= (col_q == '0);
            out_last_column  <= (col_q == LastCol);
            out_valid        <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef PIXEL_READER_ERRCNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_cnt_q <= '0;
      end else if (sof_error && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign error_count = err_cnt_q;
`else
   assign error_count = '0;
`endif

endmodule

// File: tb/tb_pixel_column_reader.sv
// Self-checking bench for pixel_column_reader (PipelineHeight=5, ImageWidth=4).
// Directed table + sequences, then random traffic against a byte-list reference model.
module tb_pixel_column_reader;

   import pixel_column_reader_pkg::*;

   localparam int H = 5;
   localparam int W = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic        in_ready;
   PixelArray   out_pixels;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_first_column;
   logic        out_last_column;
   logic        sync_error;
   logic [15:0] error_count;

   always #5 clock = ~clock;

   pixel_column_reader #(
      .PipelineHeight (H),
      .ImageWidth     (W)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .in_data          (in_data),
      .in_valid         (in_valid),
      .in_sof           (in_sof),
      .in_ready         (in_ready),
      .out_pixels       (out_pixels),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_first_column (out_first_column),
      .out_last_column  (out_last_column),
      .sync_error       (sync_error),
      .error_count      (error_count)
   );

   typedef struct {
      PixelArray px;
      bit        first;
      bit        last;
   } col_t;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       sof;
      logic       rdy;
      logic       exp_ready;
      logic       exp_valid;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a frame is W columns of 3*H bytes, sof restarts it.
   col_t       expq[$];
   logic [7:0] mb[$];
   bit         synced;
   int         mcol;
   int         errs;
   bit         err_pend;

   logic s_in_ready, s_out_valid, s_acc, s_serr;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_errcnt();
`ifdef PIXEL_READER_ERRCNT_EN
      return (errs > 65535) ? 16'hFFFF : 16'(errs);
`else
      return 16'h0;
`endif
   endfunction

   task automatic model_clear();
      expq.delete();
      mb.delete();
      synced   = 0;
      mcol     = 0;
      errs     = 0;
      err_pend = 0;
   endtask

   task automatic model_byte(input logic [7:0] d, input logic sof);
      col_t c;
      if (sof) begin
         if (synced && (mb.size() != 0 || mcol != 0)) begin
            errs++;
            err_pend = 1;
         end
         mb.delete();
         mb.push_back(d);
         mcol   = 0;
         synced = 1;
      end else if (synced) begin
         mb.push_back(d);
         if (mb.size() == 3 * H) begin
            for (int r = 0; r < H; r++)
               c.px[r] = {mb[3*r], mb[3*r+1], mb[3*r+2]};
            c.first = (mcol == 0);
            c.last  = (mcol == W - 1);
            expq.push_back(c);
            mb.delete();
            mcol++;
            if (mcol == W) begin
               mcol   = 0;
               synced = 0;
            end
         end
      end
   endtask

   // One clock: drive, check everything at negedge, update model, step.
   task automatic cycle(input logic v, input logic [7:0] d,
                        input logic sof, input logic rdy);
      bit   held, completing, exp_rdy;
      col_t c;
      in_valid  = v;
      in_data   = d;
      in_sof    = sof;
      out_ready = rdy;
      @(negedge clock);
      held       = (expq.size() != 0);
      completing = synced && (mb.size() == 3 * H - 1);
      exp_rdy    = !(held && !rdy) || !completing;
      s_in_ready  = in_ready;
      s_out_valid = out_valid;
      s_serr      = sync_error;
      s_acc       = v && in_ready;
      chk("out_valid", out_valid, held);
      chk("in_ready", in_ready, exp_rdy);
      chk("sync_error", sync_error, err_pend);
      chk("error_count", error_count, exp_errcnt());
      err_pend = 0;
      if (held) begin
         c = expq[0];
         chk("out_pixels", out_pixels, c.px);
         chk("out_first_column", out_first_column, c.first);
         chk("out_last_column", out_last_column, c.last);
         if (rdy) void'(expq.pop_front());
      end
      if (v && in_ready) model_byte(d, sof);
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic sof, input logic rdy);
      int n;
      n = 0;
      do begin
         cycle(1'b1, d, sof, rdy);
         n++;
      end while (!s_acc && n < 20);
      if (!s_acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: byte %0h not accepted in 20 cycles", d);
      end
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_pixels", out_pixels, '0);
      chk("rst_first", out_first_column, 1'b0);
      chk("rst_last", out_last_column, 1'b0);
      chk("rst_sync_error", sync_error, 1'b0);
      chk("rst_error_count", error_count, 16'h0);
      chk("rst_in_ready", in_ready, 1'b1);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      model_clear();
   endtask

   vec_t tbl[16];

   initial begin
      logic [7:0] rd;
      logic       rv, rs, rr;

      for (int i = 0; i < 15; i++)
         tbl[i] = '{1'b1, 8'(i + 1), logic'(i == 0), 1'b1, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};

      @(posedge clock);
      #1;
      do_reset();

      // First column, bytes 1..15, then held with out_ready low.
      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].sof, tbl[i].rdy);
         chk("tbl_in_ready", s_in_ready, tbl[i].exp_ready);
         chk("tbl_out_valid", s_out_valid, tbl[i].exp_valid);
      end
      chk("col0_pixel0", out_pixels[0], {8'd1, 8'd2, 8'd3});
      chk("col0_pixel4", out_pixels[4], {8'd13, 8'd14, 8'd15});
      chk("col0_first", out_first_column, 1'b1);

      // Rest of the frame, then bytes without sof are dropped.
      for (int b = 16; b <= 60; b++) send(8'(b), 1'b0, 1'b1);
      chk("col3_last", out_last_column, 1'b1);
      chk("col3_first", out_first_column, 1'b0);
      for (int b = 0; b < 7; b++) send(8'(100 + b), 1'b0, 1'b1);
      cycle(1'b0, 8'h0, 1'b0, 1'b1);
      chk("drop_no_output", out_valid, 1'b0);

      // Backpressure: only the second column's final byte stalls.
      do_reset();
      for (int b = 1; b <= 29; b++) send(8'(b), logic'(b == 1), 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 8'd30, 1'b0, 1'b0);
         chk("bp_stall", s_in_ready, 1'b0);
      end
      send(8'd30, 1'b0, 1'b1);
      chk("same_cycle_valid", out_valid, 1'b1);
      chk("same_cycle_pix0", out_pixels[0], {8'd16, 8'd17, 8'd18});
      chk("same_cycle_pix4", out_pixels[4], {8'd28, 8'd29, 8'd30});
      cycle(1'b0, 8'h0, 1'b0, 1'b1);

      // Stray sof on byte 8 of a column.
      do_reset();
      for (int b = 1; b <= 7; b++) send(8'(b), logic'(b == 1), 1'b1);
      send(8'd8, 1'b1, 1'b1);
      cycle(1'b0, 8'h0, 1'b0, 1'b1);
      chk("serr_pulse", s_serr, 1'b1);
`ifdef PIXEL_READER_ERRCNT_EN
      chk("errcnt_one", error_count, 16'd1);
`else
      chk("errcnt_zero", error_count, 16'd0);
`endif
      cycle(1'b0, 8'h0, 1'b0, 1'b1);
      chk("serr_once", s_serr, 1'b0);
      for (int b = 9; b <= 22; b++) send(8'(b), 1'b0, 1'b1);
      chk("resync_valid", out_valid, 1'b1);
      chk("resync_first", out_first_column, 1'b1);
      chk("resync_pix0", out_pixels[0], {8'd8, 8'd9, 8'd10});

      // Reset in the middle of a column.
      cycle(1'b0, 8'h0, 1'b0, 1'b1);
      for (int b = 1; b <= 8; b++) send(8'(b), logic'(b == 1), 1'b1);
      do_reset();
      for (int b = 0; b < 20; b++) send(8'(b), 1'b0, 1'b1);
      cycle(1'b0, 8'h0, 1'b0, 1'b1);
      chk("post_reset_silent", out_valid, 1'b0);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         rv = ($urandom_range(0, 9) < 8);
         rd = 8'($urandom);
         rs = synced ? ($urandom_range(0, 299) == 0)
                     : ($urandom_range(0, 3) == 0);
         rr = ($urandom_range(0, 9) < 6);
         cycle(rv, rd, rs, rr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
